// File: rtl/proc_pkg.sv
// Shared types and instruction-field positions for the instruction sequencer.
// INSTR_SEQUENCER_STEP_EN adds the PAUSE state used by single-step mode.
package proc_pkg;
   localparam int OPC_W    = 3;
   localparam int IR_W     = 8;
   localparam int OPC_MSB  = 7;
   localparam int OPC_LSB  = 5;
   localparam int RD_MSB   = 4;
   localparam int RD_LSB   = 3;
   localparam int RS_MSB   = 2;
   localparam int RS_LSB   = 1;
   localparam int LAST_BIT = 0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      WB,
      HALT
`ifdef INSTR_SEQUENCER_STEP_EN
      , PAUSE
`endif
   } state_e;
endpackage

// File: rtl/control_unit.sv
// Opcode decoder: maps an opcode to the ALU select and the register-write request.
module control_unit
   import proc_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic [OPC_W-1:0] alu_ctrl,
   output logic             reg_write
);
   always_comb begin
      alu_ctrl  = opcode;
      reg_write = 1'b1;
   end
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer for an 8-bit instruction stream.
// Define INSTR_SEQUENCER_STEP_EN for single-step mode (step port, PAUSE after each WB).
module instr_sequencer
   import proc_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
`ifdef INSTR_SEQUENCER_STEP_EN
   input  logic            step,
`endif
   output logic [PC_W-1:0] imem_addr,
   input  logic [7:0]      imem_rdata,
   input  logic            imem_valid,
   output logic [2:0]      alu_ctrl,
   output logic [1:0]      rd_addr,
   output logic [1:0]      rs_addr,
   output logic            reg_write,
   output logic            busy,
   output logic            halted,
   output logic [PC_W-1:0] pc
);
   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [IR_W-1:0]  ir_q, ir_d;
   logic [OPC_W-1:0] cu_alu_ctrl;
   logic             cu_reg_write;
   logic             in_exec_window;

   control_unit u_control_unit (
      .opcode    (ir_q[OPC_MSB:OPC_LSB]),
      .alu_ctrl  (cu_alu_ctrl),
      .reg_write (cu_reg_write)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               pc_d    = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (imem_valid) begin
               ir_d    = imem_rdata;
               state_d = DECODE;
            end
         end
         DECODE: state_d = EXEC;
         EXEC:   state_d = WB;
         WB: begin
            pc_d = pc_q + PC_W'(1);
`ifdef INSTR_SEQUENCER_STEP_EN
            state_d = PAUSE;
`else
            state_d = ir_q[LAST_BIT] ? HALT : FETCH;
`endif
         end
`ifdef INSTR_SEQUENCER_STEP_EN
         PAUSE: begin
            if (step) state_d = ir_q[LAST_BIT] ? HALT : FETCH;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Decoded fields are only presented while an instruction is in flight.
   always_comb begin
      in_exec_window = (state_q == DECODE) || (state_q == EXEC) || (state_q == WB);
      alu_ctrl  = in_exec_window ? cu_alu_ctrl : '0;
      rd_addr   = in_exec_window ? ir_q[RD_MSB:RD_LSB] : '0;
      rs_addr   = in_exec_window ? ir_q[RS_MSB:RS_LSB] : '0;
      reg_write = cu_reg_write && (state_q == WB);
      busy      = (state_q == FETCH) || in_exec_window;
`ifdef INSTR_SEQUENCER_STEP_EN
      if (state_q == PAUSE) busy = 1'b1;
`endif
      halted    = (state_q == HALT);
      imem_addr = (state_q == FETCH) ? pc_q : '0;
      pc        = pc_q;
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer; runs a PC_W=8 and a PC_W=2 instance in lockstep.
module tb_instr_sequencer;
   logic       clk;
   logic       rst;
   logic       start;
   logic       step;
   logic [7:0] imem_rdata;
   logic       imem_valid;

   logic [7:0] a_imem_addr, a_pc;
   logic [2:0] a_alu_ctrl;
   logic [1:0] a_rd_addr, a_rs_addr;
   logic       a_reg_write, a_busy, a_halted;

   logic [1:0] b_imem_addr, b_pc;
   logic [2:0] b_alu_ctrl;
   logic [1:0] b_rd_addr, b_rs_addr;
   logic       b_reg_write, b_busy, b_halted;

   typedef struct packed {
      logic [2:0] alu;
      logic [1:0] rd;
      logic [1:0] rs;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   instr_sequencer #(.PC_W(8)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
`ifdef INSTR_SEQUENCER_STEP_EN
      .step       (step),
`endif
      .imem_addr  (a_imem_addr),
      .imem_rdata (imem_rdata),
      .imem_valid (imem_valid),
      .alu_ctrl   (a_alu_ctrl),
      .rd_addr    (a_rd_addr),
      .rs_addr    (a_rs_addr),
      .reg_write  (a_reg_write),
      .busy       (a_busy),
      .halted     (a_halted),
      .pc         (a_pc)
   );

   instr_sequencer #(.PC_W(2)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
`ifdef INSTR_SEQUENCER_STEP_EN
      .step       (step),
`endif
      .imem_addr  (b_imem_addr),
      .imem_rdata (imem_rdata),
      .imem_valid (imem_valid),
      .alu_ctrl   (b_alu_ctrl),
      .rd_addr    (b_rd_addr),
      .rs_addr    (b_rs_addr),
      .reg_write  (b_reg_write),
      .busy       (b_busy),
      .halted     (b_halted),
      .pc         (b_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Entered in a FETCH cycle; leaves the DUT observed in its WB cycle.
   task automatic do_instr(input logic [7:0] instr, input int delay, input int addr,
                           input bit pulse_start);
      exp_t e;
      for (int i = 0; i < delay; i++) begin
         start = pulse_start;
         chk("fetch_wait_addr_a", 32'(a_imem_addr), addr);
         chk("fetch_wait_addr_b", 32'(b_imem_addr), addr % 4);
         chk("fetch_wait_no_write", 32'(a_reg_write), 0);
         tick();
      end
      start = 1'b0;
      chk("fetch_addr_a", 32'(a_imem_addr), addr);
      chk("fetch_addr_b", 32'(b_imem_addr), addr % 4);
      chk("fetch_busy", 32'(a_busy), 1);
      imem_valid = 1'b1;
      imem_rdata = instr;
      e.alu = instr[7:5];
      e.rd  = instr[4:3];
      e.rs  = instr[2:1];
      sb.push_back(e);
      tick();
      imem_rdata = ~instr;
      start      = pulse_start;
      chk("decode_alu", 32'(a_alu_ctrl), 32'(instr[7:5]));
      chk("decode_rd", 32'(a_rd_addr), 32'(instr[4:3]));
      chk("decode_rs", 32'(a_rs_addr), 32'(instr[2:1]));
      chk("decode_no_write", 32'(a_reg_write), 0);
      tick();
      start      = 1'b0;
      imem_valid = 1'b0;
      chk("exec_alu", 32'(a_alu_ctrl), 32'(instr[7:5]));
      chk("exec_rd", 32'(a_rd_addr), 32'(instr[4:3]));
      chk("exec_rs", 32'(a_rs_addr), 32'(instr[2:1]));
      chk("exec_no_write", 32'(a_reg_write), 0);
      tick();
      chk("wb_write_a", 32'(a_reg_write), 1);
      chk("wb_write_b", 32'(b_reg_write), 1);
      chk("sb_not_empty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("wb_alu", 32'(a_alu_ctrl), 32'(e.alu));
         chk("wb_rd", 32'(a_rd_addr), 32'(e.rd));
         chk("wb_rs", 32'(a_rs_addr), 32'(e.rs));
         chk("wb_alu_b", 32'(b_alu_ctrl), 32'(e.alu));
      end
   endtask

   task automatic after_wb(input bit last);
      tick();
`ifdef INSTR_SEQUENCER_STEP_EN
      for (int i = 0; i < 3; i++) begin
         imem_valid = 1'b1;
         chk("pause_busy", 32'(a_busy), 1);
         chk("pause_halted", 32'(a_halted), 0);
         chk("pause_no_write", 32'(a_reg_write), 0);
         chk("pause_no_fetch", 32'(a_imem_addr), 0);
         tick();
      end
      imem_valid = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
`endif
      chk("post_wb_halted", 32'(a_halted), 32'(last));
      chk("post_wb_busy", 32'(a_busy), 32'(!last));
      chk("post_wb_no_write", 32'(a_reg_write), 0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      step       = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_halted", 32'(a_halted), 0);
      chk("rst_reg_write", 32'(a_reg_write), 0);
      chk("rst_pc", 32'(a_pc), 0);
      chk("rst_imem_addr", 32'(a_imem_addr), 0);
      chk("rst_alu", 32'(a_alu_ctrl), 0);
      chk("rst_rd", 32'(a_rd_addr), 0);
      chk("rst_rs", 32'(a_rs_addr), 0);
      imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      chk("idle_ignores_valid", 32'(a_busy), 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      do_instr(8'b010_01_10_0, 0, 0, 1'b0);
      after_wb(1'b0);
      chk("pc_after_first", 32'(a_pc), 1);

      do_instr(8'b101_11_00_0, 5, 1, 1'b1);
      after_wb(1'b0);
      chk("pc_after_second", 32'(a_pc), 2);

      do_instr(8'b111_00_11_1, 0, 2, 1'b0);
      after_wb(1'b1);
      imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      chk("halt_holds", 32'(a_halted), 1);
      chk("halt_alu_zero", 32'(a_alu_ctrl), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_addr", 32'(a_imem_addr), 0);
      chk("restart_pc", 32'(a_pc), 0);
      chk("restart_busy", 32'(a_busy), 1);
      chk("restart_halted", 32'(a_halted), 0);

      imem_valid = 1'b1;
      imem_rdata = 8'b011_10_01_0;
      tick();
      imem_valid = 1'b0;
      tick();
      chk("abort_exec_alu", 32'(a_alu_ctrl), 3);
      rst = 1'b1;
      tick();
      chk("abort_no_write", 32'(a_reg_write), 0);
      chk("abort_busy", 32'(a_busy), 0);
      chk("abort_halted", 32'(a_halted), 0);
      chk("abort_pc", 32'(a_pc), 0);
      chk("abort_alu", 32'(a_alu_ctrl), 0);
      rst = 1'b0;
      tick();
      chk("abort_still_no_write", 32'(a_reg_write), 0);
      chk("abort_idle", 32'(a_busy), 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      do_instr(8'b000_00_01_0, 0, 0, 1'b1);
      after_wb(1'b0);
      do_instr(8'b001_01_10_0, 1, 1, 1'b1);
      after_wb(1'b0);
      do_instr(8'b100_10_11_0, 0, 2, 1'b0);
      after_wb(1'b0);
      do_instr(8'b110_11_00_0, 2, 3, 1'b1);
      after_wb(1'b0);
      chk("wrap_pc_b", 32'(b_pc), 0);
      chk("wrap_addr_b", 32'(b_imem_addr), 0);
      chk("nowrap_pc_a", 32'(a_pc), 4);
      chk("wrap_busy_b", 32'(b_busy), 1);
      do_instr(8'b110_01_01_1, 0, 4, 1'b0);
      after_wb(1'b1);
      chk("wrap_halted_b", 32'(b_halted), 1);
      chk("final_pc_b", 32'(b_pc), 1);
      chk("sb_drained", 32'(sb.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse; starts execution from address 0.
REQ-005 SHALL have port imem_addr  output  PC_W  instruction fetch address.
REQ-006 SHALL have port imem_rdata  input  8  instruction word: [7:5] opcode, [4:3] rd, [2:1] rs, [0] last.
REQ-007 SHALL have port imem_valid  input  1  imem_rdata valid this cycle.
REQ-008 SHALL have port alu_ctrl  output  3  ALU operation select.
REQ-009 SHALL have port rd_addr / rs_addr  output  2 each  register-file destination / source.
REQ-010 SHALL have port reg_write  output  1  register-file write enable.
REQ-011 SHALL have ports busy and halted  output  1 each  status flags.
REQ-012 SHALL have port pc  output  PC_W  current program counter.

Function
REQ-013 SHALL use the states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-014 IDLE: on start, SHALL set pc=0 and go to FETCH; otherwise SHALL remain in IDLE.
REQ-015 FETCH: SHALL drive imem_addr=pc and wait any number of cycles for imem_valid; on the imem_valid cycle it SHALL latch imem_rdata into the IR and go to DECODE.
REQ-016 DECODE SHALL last exactly 1 cycle and SHALL drive rs_addr, rd_addr and alu_ctrl from the IR.
REQ-017 EXEC SHALL last exactly 1 cycle and SHALL hold the same rs_addr, rd_addr and alu_ctrl values.
REQ-018 WB SHALL last exactly 1 cycle, during which reg_write=1 and pc increments modulo 2^PC_W (wraps to 0).
REQ-019 After WB, SHALL go to HALT if IR[0]=1, otherwise to FETCH.
REQ-020 alu_ctrl SHALL equal the opcode for all 8 codes.
REQ-021 reg_write SHALL be 1 only in WB.
REQ-022 Latency: with imem_valid in cycle N, reg_write SHALL be high in cycle N+3; minimum 4 cycles per instruction.
REQ-023 busy SHALL be 1 in FETCH, DECODE, EXEC and WB; halted SHALL be 1 only in HALT.
REQ-024 HALT: start SHALL restart at pc=0 in FETCH; otherwise SHALL remain in HALT.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 imem_valid SHALL be ignored outside FETCH.
REQ-027 When not in DECODE, EXEC or WB, alu_ctrl, rd_addr and rs_addr SHALL be 0.

Reset
REQ-028 rst SHALL take priority over all other inputs in any state, including mid-instruction.
REQ-029 On the edge where rst=1, the block SHALL enter IDLE with pc=0, IR=0, reg_write=0, busy=0 and halted=0; the interrupted instruction SHALL never write.
REQ-030 imem_addr, alu_ctrl, rd_addr and rs_addr SHALL reset to 0.

Configuration
REQ-031 Macro INSTR_SEQUENCER_STEP_EN SHALL compile in single-step mode.
REQ-032 With INSTR_SEQUENCER_STEP_EN defined, the block SHALL add port step (input, 1), and after WB it SHALL wait in the added state PAUSE (busy=1) until step=1, then take the REQ-019 transition; rst in PAUSE SHALL behave as in REQ-028.
REQ-033 Without INSTR_SEQUENCER_STEP_EN, the block SHALL have no step port and no PAUSE state, and REQ-019 SHALL apply directly.

Structure
REQ-034 Shared package proc_pkg SHALL hold the state enum, instruction field bit positions and the opcode width constant (3).
REQ-035 Opcode decode SHALL instantiate the existing control_unit sub-module; its reg_write output SHALL be ANDed with (state==WB).

Verification
REQ-036 The bench SHALL cover: rst, then start, with imem_valid given at once, instr 8'b010_01_10_0 at addr 0 -> reg_write high in cycle 3 after valid, alu_ctrl=3'b010, rd_addr=1, rs_addr=2, pc increments to 1.
REQ-037 The bench SHALL cover: imem_valid delayed 5 cycles -> FETCH holds imem_addr constant, and no reg_write occurs until valid +3.
REQ-038 The bench SHALL cover: instr with bit0=1 at addr 2 -> after its WB, halted=1 and busy=0; a following start -> imem_addr=0.
REQ-039 The bench SHALL cover: rst asserted during EXEC -> next cycle IDLE, pc=0, and no reg_write pulse.
REQ-040 The bench SHALL cover: PC_W=2 with 4 non-last instrs -> pc wraps 3->0 and fetch continues at 0; start pulses while busy are ignored.
REQ-041 The bench SHALL cover, with INSTR_SEQUENCER_STEP_EN defined: the block holds PAUSE after each WB until step=1, then the next fetch starts.
